// File: rtl/filter2d_pkg.sv
`default_nettype none
// ============================================================================
// filter2d_pkg : shared state encoding, constants and sizing helper
// Rev 1.0
// ============================================================================
package filter2d_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int NUM_COEF = 9;

    // Width able to hold the value n itself (counters run 0..n inclusive).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter2d_pacer.sv
`default_nettype none
// ============================================================================
// filter2d_pacer : spaces accepted source pixels GAP idle cycles apart
// Rev 1.0
// ============================================================================
module filter2d_pacer #(
    parameter int GAP = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic src_valid,
    output logic src_ready,
    output logic xfer
);

    localparam int PW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    logic [PW-1:0] pace;

    assign src_ready = enable && (pace == '0);
    assign xfer      = src_ready && src_valid;

    // Reload on every transfer; a stalled source simply leaves pace parked at 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pace <= '0;
        end else if (xfer) begin
            pace <= PW'(GAP);
        end else if (pace != '0) begin
            pace <= pace - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/filter2d_ctrl.sv
`default_nettype none
// ============================================================================
// filter2d_ctrl : per-frame coefficient load, paced pixel stream and drain
// Rev 1.0
// ============================================================================
module filter2d_ctrl
    import filter2d_pkg::*;
#(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int GAP      = 16,
    parameter int DRAIN_TO = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] frame_cnt,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       cfg_we,
    input  logic [3:0] cfg_idx,
    input  logic [7:0] cfg_data,
    input  logic       src_valid,
    input  logic [7:0] src_data,
    output logic       src_ready,
    output logic       f_strb,
    output logic [7:0] f_data,
    output logic       f_h_write,
    output logic [3:0] f_h_idx,
    output logic [7:0] f_h_data,
    input  logic       f_o_strb
);

    localparam int             TOTAL_I = IMG_W * IMG_H;
    localparam int             CW      = cnt_width(TOTAL_I);
    localparam int             DW      = cnt_width(DRAIN_TO);
    localparam logic [CW-1:0]  TOTAL   = CW'(TOTAL_I);
    localparam logic [CW-1:0]  LAST    = CW'(TOTAL_I - 1);
    localparam logic [DW-1:0]  DRAIN_L = DW'(DRAIN_TO - 1);
    localparam logic [3:0]     COEF_L  = 4'(NUM_COEF - 1);

    state_t        state;
    state_t        state_nx;
    logic [7:0]    shadow [NUM_COEF];
    logic [3:0]    load_k;
    logic [7:0]    frames_left;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic [DW-1:0] drain_cnt;
    logic          zero_done;

    logic accept;
    logic load_last;
    logic stream_en;
    logic xfer;
    logic last_xfer;
    logic out_full;
    logic drain_exp;
    logic frame_end;
    logic out_active;

    assign accept     = (state == ST_IDLE) && start && (frame_cnt != 8'd0);
    assign load_last  = (state == ST_LOAD) && (load_k == COEF_L);
    assign stream_en  = (state == ST_STREAM) && (in_cnt < TOTAL);
    assign last_xfer  = xfer && (in_cnt == LAST);
    assign out_full   = (out_cnt == TOTAL);
    assign drain_exp  = (drain_cnt == DRAIN_L);
    assign frame_end  = (state == ST_DRAIN) && (out_full || drain_exp);
    assign out_active = (state == ST_STREAM) || (state == ST_DRAIN);

    filter2d_pacer #(
        .GAP       (GAP)
    ) u_pacer (
        .clk       (clk),
        .reset     (reset),
        .clear     (load_last),
        .enable    (stream_en),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .xfer      (xfer)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE) || zero_done;
        f_h_write = 1'b0;
        f_h_idx   = 4'd0;
        f_h_data  = 8'd0;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                // Shadow read is the registered value, so a same-cycle cfg write is not seen.
                f_h_write = 1'b1;
                f_h_idx   = load_k;
                f_h_data  = shadow[load_k];
                if (load_last) state_nx = ST_STREAM;
            end
            ST_STREAM: begin
                if (last_xfer) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (frame_end) state_nx = (frames_left == 8'd1) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_COEF; k++) shadow[k] <= 8'd0;
            load_k      <= 4'd0;
            frames_left <= 8'd0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            drain_cnt   <= '0;
            zero_done   <= 1'b0;
            err         <= 1'b0;
            f_strb      <= 1'b0;
            f_data      <= 8'd0;
        end else begin
            if (cfg_we && (cfg_idx <= COEF_L)) shadow[cfg_idx] <= cfg_data;

            f_strb <= xfer;
            if (xfer) f_data <= src_data;

            // An empty run completes without ever leaving IDLE.
            zero_done <= (state == ST_IDLE) && start && (frame_cnt == 8'd0);

            if (accept) begin
                frames_left <= frame_cnt;
                err         <= 1'b0;
                load_k      <= 4'd0;
            end else if (state == ST_LOAD) begin
                load_k <= load_k + 4'd1;
            end

            if (load_last) begin
                in_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (xfer) in_cnt <= in_cnt + 1'b1;
                if (out_active && f_o_strb && !out_full) out_cnt <= out_cnt + 1'b1;
            end

            if (state == ST_DRAIN) begin
                drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end

            if (frame_end) begin
                frames_left <= frames_left - 8'd1;
                load_k      <= 4'd0;
                if (!out_full) err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_filter2d_ctrl.sv
`default_nettype none
// ============================================================================
// tb_filter2d_ctrl : scoreboard bench for the frame sequencer
// Rev 1.0
// ============================================================================
module tb_filter2d_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] frame_cnt;
    logic       busy;
    logic       done;
    logic       err;
    logic       cfg_we;
    logic [3:0] cfg_idx;
    logic [7:0] cfg_data;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       f_strb;
    logic [7:0] f_data;
    logic       f_h_write;
    logic [3:0] f_h_idx;
    logic [7:0] f_h_data;
    logic       f_o_strb;

    filter2d_ctrl #(
        .IMG_W     (4),
        .IMG_H     (4),
        .GAP       (2),
        .DRAIN_TO  (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .frame_cnt (frame_cnt),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .f_strb    (f_strb),
        .f_data    (f_data),
        .f_h_write (f_h_write),
        .f_h_idx   (f_h_idx),
        .f_h_data  (f_h_data),
        .f_o_strb  (f_o_strb)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_pix [$];
    logic [11:0] exp_coef [$];
    logic [7:0]  tb_shadow [9];
    int          run_strbs, run_xfers, done_seen, d0;
    int          echo_left, stall_at, stall_left, exp_age, age;
    bit          src_en, exact_gap, exp_busy_done, have_prev, prev_done, pending;
    logic [3:0]  echo_sr;
    logic [7:0]  last_fdata;
    logic [11:0] c;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // Source: data changes only after an accepted transfer; optional one-shot stall.
    initial begin
        src_valid = 1'b0;
        src_data  = 8'h11;
        pending   = 1'b0;
        forever begin
            @(negedge clk);
            if (pending) begin
                src_data = src_data + 8'd7;
                pending  = 1'b0;
            end
            if (reset || !src_en) begin
                src_valid = 1'b0;
            end else if (stall_left > 0 && run_xfers == stall_at) begin
                src_valid = 1'b0;
                stall_left--;
            end else begin
                src_valid = 1'b1;
            end
            if (src_valid && src_ready && !reset) begin
                exp_pix.push_back(src_data);
                run_xfers++;
                pending = 1'b1;
            end
        end
    end

    // Filter model: echo each strobe back four cycles later, up to echo_left times.
    initial begin
        f_o_strb = 1'b0;
        echo_sr  = 4'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                echo_sr  = 4'd0;
                f_o_strb = 1'b0;
            end else begin
                f_o_strb = echo_sr[3];
                echo_sr  = {echo_sr[2:0], f_strb && (echo_left > 0)};
                if (f_strb && echo_left > 0) echo_left--;
            end
        end
    end

    // Output monitor.
    initial begin
        age = 0; have_prev = 0; prev_done = 0; last_fdata = 8'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_fdata = 8'd0;
                have_prev  = 0;
                prev_done  = 0;
                age        = 0;
            end else begin
                age++;
                if (prev_done) check_eq("busy_after_done", busy, 0);
                prev_done = done;
                if (done) begin
                    done_seen++;
                    check_eq("busy_at_done", busy, exp_busy_done);
                    if (exp_age >= 0) check_eq("done_latency", age, exp_age);
                end
                if (f_h_write) begin
                    have_prev = 0;
                    if (exp_coef.size() == 0) begin
                        check_eq("coef_extra", 1, 0);
                    end else begin
                        c = exp_coef.pop_front();
                        check_eq("coef_idx", f_h_idx, c[11:8]);
                        check_eq("coef_data", f_h_data, c[7:0]);
                    end
                end
                if (f_strb) begin
                    run_strbs++;
                    if (have_prev) begin
                        if (exact_gap) check_eq("strb_gap", age, 3);
                        else check_eq("strb_gap_min", age >= 3, 1);
                    end
                    have_prev = 1;
                    age = 0;
                    if (exp_pix.size() == 0) check_eq("pix_extra", 1, 0);
                    else check_eq("pix_data", f_data, exp_pix.pop_front());
                    last_fdata = f_data;
                end else begin
                    check_eq("fdata_hold", f_data, last_fdata);
                end
            end
        end
    end

    task automatic write_cfg(input logic [3:0] idx, input logic [7:0] data);
        cfg_we = 1'b1; cfg_idx = idx; cfg_data = data;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic push_coefs();
        for (int k = 0; k < 9; k++) exp_coef.push_back({4'(k), tb_shadow[k]});
    endtask

    task automatic start_run(input logic [7:0] n);
        push_coefs();
        run_strbs = 0; run_xfers = 0; d0 = done_seen;
        src_en = 1'b1; start = 1'b1; frame_cnt = n;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_on_start", busy, 1);
        check_eq("err_clr_on_start", err, 0);
    endtask

    task automatic finish_run(input int n_pix, input logic exp_err, input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        check_eq("done_seen", got, 1);
        check_eq("err_at_done", err, exp_err);
        check_eq("pix_count", run_strbs, n_pix);
        check_eq("pix_left", exp_pix.size(), 0);
        check_eq("coef_left", exp_coef.size(), 0);
        @(negedge clk);
        check_eq("done_once", done_seen - d0, 1);
        check_eq("err_sticky", err, exp_err);
        src_en = 1'b0;
    endtask

    task automatic zero_run();
        exp_busy_done = 0; exp_age = -1; d0 = done_seen;
        start = 1'b1; frame_cnt = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check_eq("zero_done", done, 1);
        check_eq("zero_busy", busy, 0);
        @(negedge clk);
        check_eq("zero_done_once", done_seen - d0, 1);
        check_eq("zero_done_low", done, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; frame_cnt = 8'd0;
        cfg_we = 1'b0; cfg_idx = 4'd0; cfg_data = 8'd0;
        src_en = 0; echo_left = 0; stall_at = 0; stall_left = 0;
        exact_gap = 0; exp_age = -1; exp_busy_done = 1;
        run_strbs = 0; run_xfers = 0; done_seen = 0; d0 = 0;
        for (int k = 0; k < 9; k++) tb_shadow[k] = 8'd0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ready", src_ready, 0);
        check_eq("rst_strb", f_strb, 0);
        check_eq("rst_fdata", f_data, 0);
        check_eq("rst_hwrite", f_h_write, 0);
        check_eq("rst_hidx", f_h_idx, 0);
        check_eq("rst_hdata", f_h_data, 0);
        reset = 1'b0;
        @(negedge clk);

        zero_run();

        // Single frame with a mid-frame source stall and full echo.
        for (int k = 0; k < 9; k++) begin
            write_cfg(4'(k), 8'(k + 1));
            tb_shadow[k] = 8'(k + 1);
        end
        write_cfg(4'd9, 8'hEE);
        write_cfg(4'd15, 8'hEE);
        exact_gap = 0; stall_at = 6; stall_left = 5;
        echo_left = 16; exp_age = 6; exp_busy_done = 1;
        start_run(8'd1);
        finish_run(16, 1'b0, 300);

        // One output missing: drain times out after 32 cycles.
        exact_gap = 1; echo_left = 15; exp_age = 32;
        start_run(8'd1);
        finish_run(16, 1'b1, 300);
        zero_run();
        check_eq("err_kept_zero_start", err, 1);

        // Two frames with a coefficient rewrite while frame 1 streams.
        exp_busy_done = 1; echo_left = 32; exp_age = 6;
        start_run(8'd2);
        for (int i = 0; i < 200 && run_strbs < 3; i++) @(negedge clk);
        check_eq("reach_pix3", run_strbs >= 3, 1);
        write_cfg(4'd0, 8'h55);
        tb_shadow[0] = 8'h55;
        push_coefs();
        finish_run(32, 1'b0, 500);

        // Reset during streaming, then a clean rerun.
        echo_left = 16;
        start_run(8'd1);
        for (int i = 0; i < 200 && run_strbs < 7; i++) @(negedge clk);
        check_eq("reach_pix7", run_strbs >= 7, 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_strb", f_strb, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_ready", src_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_pix.delete();
        exp_coef.delete();
        for (int k = 0; k < 9; k++) tb_shadow[k] = 8'd0;
        echo_left = 0; src_en = 0; d0 = done_seen;
        repeat (5) @(negedge clk);
        check_eq("abort_no_done", done_seen - d0, 0);
        echo_left = 16; exp_age = 6; exact_gap = 1;
        start_run(8'd1);
        finish_run(16, 1'b0, 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/filter2d_ctrl.md
FILTER2D_CTRL -- requirements
Module: filter2d_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 256, meaning pixels per line.
REQ-002 SHALL have parameter IMG_H, default 256, meaning lines per frame.
REQ-003 SHALL have parameter GAP, default 16, meaning idle cycles inserted after each pixel strobe.
REQ-004 SHALL have parameter DRAIN_TO, default 4096, meaning the drain timeout in cycles.
REQ-005 Ports, in order:
- clk  in  1  sole clock; one clock; all logic on rising edge.
- reset  in  1  reset is synchronous and active-high.
- start  in  1  one-cycle run request.
- frame_cnt  in  8  frames to process; sampled at start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky drain timeout flag.
- cfg_we  in  1  coefficient shadow write.
- cfg_idx  in  4  shadow index 0..8.
- cfg_data  in  8  coefficient value.
- src_valid  in  1  source pixel available.
- src_data  in  8  source pixel.
- src_ready  out  1  pixel accepted when valid&ready.
- f_strb  out  1  pixel strobe to filter2d.
- f_data  out  8  pixel to filter2d.
- f_h_write  out  1  coefficient write to filter2d.
- f_h_idx  out  4  coefficient index.
- f_h_data  out  8  coefficient value.
- f_o_strb  in  1  filter2d output strobe.

Function
REQ-006 SHALL hold a 9-entry by 8-bit coefficient shadow, writable on any cycle when cfg_we=1 and cfg_idx<=8; writes with cfg_idx>8 SHALL be ignored.
REQ-007 SHALL implement the states IDLE, LOAD, STREAM, DRAIN and DONE.
REQ-008 IDLE->LOAD SHALL occur on start=1 with frame_cnt!=0; start with frame_cnt=0 SHALL pulse done the next cycle without touching err; start SHALL be ignored outside IDLE.
REQ-009 LOAD SHALL last 9 cycles, driving f_h_write=1 with f_h_idx=k and f_h_data=shadow[k] for k=0..8; the value is sampled in the same cycle as driven, so a same-cycle cfg write to index k is not seen.
REQ-010 LOAD SHALL be followed by STREAM, with the in-counter, the out-counter and the pace counter all cleared.
REQ-011 In STREAM, src_ready SHALL be 1 only when the pace counter is 0 and the in-counter is below IMG_W*IMG_H.
REQ-012 On a transfer, f_strb=1 and f_data=src_data SHALL appear registered on the next cycle, the pace counter SHALL reload GAP and then decrement each cycle to 0, and the in-counter SHALL increment.
REQ-013 Consecutive f_strb pulses SHALL be separated by at least GAP low cycles; if src_valid is low, the pause is extended with no bubble penalty.
REQ-014 f_data SHALL be held at the last value while f_strb=0.
REQ-015 After the IMG_W*IMG_H-th transfer, the state SHALL move to DRAIN.
REQ-016 The out-counter SHALL count f_o_strb in STREAM and DRAIN, SHALL saturate at IMG_W*IMG_H, and f_o_strb SHALL be ignored in IDLE, LOAD and DONE.
REQ-017 In DRAIN, reaching out-counter=IMG_W*IMG_H SHALL end the frame.
REQ-018 If DRAIN_TO cycles elapse in DRAIN without out-counter=IMG_W*IMG_H, err SHALL be set and the frame SHALL end.
REQ-019 At frame end, the remaining-frame counter SHALL decrement; if nonzero the state SHALL go to LOAD (coefficients reloaded per frame), else to DONE.
REQ-020 DONE SHALL pulse done=1 for one cycle and return to IDLE.
REQ-021 busy SHALL equal (state!=IDLE).
REQ-022 err SHALL clear on accepted start only.
REQ-023 If the in-counter and out-counter events of one cycle coincide, both SHALL update independently.

Reset
REQ-024 When reset=1 at a clock edge, the state SHALL be IDLE and all counters SHALL be 0.
REQ-025 Reset values: busy=0, done=0, err=0, src_ready=0, f_strb=0, f_data=0, f_h_write=0, f_h_idx=0, f_h_data=0, shadow entries all 0.
REQ-026 Reset mid-frame SHALL abort immediately with no done pulse; outputs SHALL take reset values the next cycle.

Structure
REQ-027 A shared package SHALL hold the state enum, NUM_COEF=9, and the counter width function clog2(IMG_W*IMG_H+1).
REQ-028 The pacing/handshake counter SHALL be one sub-module, filter2d_pacer (GAP reload, ready generation); the FSM, shadow and counters SHALL stay in filter2d_ctrl.

Verification (IMG_W=4, IMG_H=4, GAP=2, DRAIN_TO=32 unless stated)
REQ-029 Write shadow 1..9, start with frame_cnt=1 -> 9 f_h_write cycles with idx 0..8 and data 1..9, then 16 f_strb pulses each 3 cycles apart.
REQ-030 Toggle src_valid low for 5 cycles mid-frame -> no f_strb during the gap, no data loss, and all 16 pixels delivered in order.
REQ-031 Echo f_o_strb 4 cycles after each f_strb -> done pulses once, err=0, busy falls the same cycle done falls.
REQ-032 Return only 15 f_o_strb -> err=1 after 32 DRAIN cycles, followed by a done pulse.
REQ-033 Set frame_cnt=2 and rewrite shadow[0]=0x55 during frame 1 -> the second LOAD drives idx0=0x55, and 32 pixels total are delivered.
REQ-034 Assert reset during STREAM at pixel 7 -> next cycle busy=0 and f_strb=0, no done pulse; a new start reruns cleanly.
